// File: rtl/exe_muldiv_seq.sv
// exe_muldiv_seq: multi-cycle RISC-V M-extension multiply/divide unit for the execute stage.
//
// It accepts one operation at a time and holds its result until writeback takes it.
//   - Multiplies use shift-add, retiring MUL_BITS multiplier bits per cycle on the operand
//     magnitudes.
//   - Divides use restoring division, one quotient bit per cycle on the operand magnitudes.
//   - Signs are corrected in a single FIX cycle, which then writes the result register.
//
// Parameters:
//   XLEN      operand/result width (even, >= 8)
//   MUL_BITS  multiplier bits retired per cycle (1, 2 or 4; divides XLEN)
//
// Ports:
//   clk, nrst         clock (rising edge), asynchronous active-low reset
//   in_valid/ready    operation handshake; in_ready is high only while idle
//   mulDiv_op         0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op_a, op_b        rs1/rs2 values
//   rd_in, we_in      destination register and write enable carried to writeback
//   flush             aborts any in-flight or held operation
//   out_valid/ready   result handshake; result, rd_out, we_out are held while out_valid
//   busy              unit not idle
module exe_muldiv_seq #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mulDiv_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            we_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic            busy
);

  localparam int unsigned NMul = XLEN / MUL_BITS;
  localparam int unsigned NDiv = XLEN;
  localparam int unsigned CntW = $clog2(XLEN + 1);

  localparam logic [CntW-1:0] LastMul = CntW'(NMul - 1);
  localparam logic [CntW-1:0] LastDiv = CntW'(NDiv - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  // State and captured operation
  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a_raw;
  logic [4:0]        r_rd;
  logic              r_we;
  logic              r_neg;
  logic              r_neg_rem;
  logic              r_div0;
  logic              r_ovf;
  logic [CntW-1:0]   r_count;
  logic [XLEN-1:0]   r_result;

  // Multiply datapath
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;

  // Divide datapath
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_divs;

  logic [1:0]        w_state_nxt;
  logic [2:0]        w_op_nxt;
  logic [XLEN-1:0]   w_a_raw_nxt;
  logic [4:0]        w_rd_nxt;
  logic              w_we_nxt;
  logic              w_neg_nxt;
  logic              w_neg_rem_nxt;
  logic              w_div0_nxt;
  logic              w_ovf_nxt;
  logic [CntW-1:0]   w_count_nxt;
  logic [XLEN-1:0]   w_result_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_mcand_nxt;
  logic [XLEN-1:0]   w_mplier_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_divs_nxt;

  // Input decode
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div0;
  logic            w_ovf;

  always_comb begin
    w_is_div   = mulDiv_op[2];
    w_a_signed = (mulDiv_op == OpMulh) || (mulDiv_op == OpMulhsu) ||
                 (mulDiv_op == OpDiv)  || (mulDiv_op == OpRem);
    w_b_signed = (mulDiv_op == OpMulh) || (mulDiv_op == OpDiv) || (mulDiv_op == OpRem);
    w_a_neg    = w_a_signed && op_a[XLEN-1];
    w_b_neg    = w_b_signed && op_b[XLEN-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    w_a_abs    = w_a_neg ? -op_a : op_a;
    w_b_abs    = w_b_neg ? -op_b : op_b;
    w_div0     = w_is_div && (op_b == '0);
    w_ovf      = ((mulDiv_op == OpDiv) || (mulDiv_op == OpRem)) &&
                 (op_a == MinNeg) && (op_b == '1);
  end

  // One shift-add step: add the multiplicand scaled by the low MUL_BITS multiplier bits.
  logic [2*XLEN-1:0] w_pp;

  always_comb begin
    w_pp = '0;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) begin
        w_pp = w_pp + (r_mcand << j);
      end
    end
  end

  // One restoring divide step; bit XLEN of the difference is the borrow.
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_shifted = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, r_divs};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  always_comb begin
    w_prod    = r_neg ? -r_acc : r_acc;
    w_quo_fix = r_neg ? -r_quo : r_quo;
    w_rem_fix = r_neg_rem ? -r_rem : r_rem;
    if (r_div0) begin
      w_quo_fix = '1;
      w_rem_fix = r_a_raw;
    end else if (r_ovf) begin
      w_quo_fix = r_a_raw;
      w_rem_fix = '0;
    end
    case (r_op)
      OpMul:                      w_fix_result = w_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  w_fix_result = w_prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              w_fix_result = w_quo_fix;
      OpRem, OpRemu:              w_fix_result = w_rem_fix;
      default:                    w_fix_result = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_a_raw_nxt   = r_a_raw;
    w_rd_nxt      = r_rd;
    w_we_nxt      = r_we;
    w_neg_nxt     = r_neg;
    w_neg_rem_nxt = r_neg_rem;
    w_div0_nxt    = r_div0;
    w_ovf_nxt     = r_ovf;
    w_count_nxt   = r_count;
    w_result_nxt  = r_result;
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divs_nxt    = r_divs;

    if (flush) begin
      // Flush wins over everything, including an offer in the same cycle.
      w_state_nxt  = StIdle;
      w_count_nxt  = '0;
      w_result_nxt = '0;
      w_rd_nxt     = '0;
      w_we_nxt     = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            w_op_nxt      = mulDiv_op;
            w_a_raw_nxt   = op_a;
            w_rd_nxt      = rd_in;
            w_we_nxt      = we_in;
            w_neg_nxt     = w_a_neg ^ w_b_neg;
            w_neg_rem_nxt = w_a_neg;
            w_div0_nxt    = w_div0;
            w_ovf_nxt     = w_ovf;
            w_count_nxt   = '0;
            w_acc_nxt     = '0;
            w_mcand_nxt   = {{XLEN{1'b0}}, w_a_abs};
            w_mplier_nxt  = w_b_abs;
            w_rem_nxt     = '0;
            w_quo_nxt     = w_a_abs;
            w_divs_nxt    = w_b_abs;
            w_state_nxt   = (w_div0 || w_ovf) ? StFix : StCalc;
          end
        end

        StCalc: begin
          w_count_nxt = r_count + CntW'(1);
          if (r_op[2]) begin
            if (!w_diff[XLEN]) begin
              w_rem_nxt = w_diff[XLEN-1:0];
              w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
            end else begin
              w_rem_nxt = w_shifted[XLEN-1:0];
              w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
            end
            if (r_count == LastDiv) begin
              w_state_nxt = StFix;
            end
          end else begin
            w_acc_nxt    = r_acc + w_pp;
            w_mcand_nxt  = r_mcand << MUL_BITS;
            w_mplier_nxt = r_mplier >> MUL_BITS;
            if (r_count == LastMul) begin
              w_state_nxt = StFix;
            end
          end
        end

        StFix: begin
          w_result_nxt = w_fix_result;
          w_state_nxt  = StDone;
        end

        StDone: begin
          if (out_ready) begin
            w_state_nxt = StIdle;
          end
        end

        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_a_raw   <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_result  <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divs    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_a_raw   <= w_a_raw_nxt;
      r_rd      <= w_rd_nxt;
      r_we      <= w_we_nxt;
      r_neg     <= w_neg_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_div0    <= w_div0_nxt;
      r_ovf     <= w_ovf_nxt;
      r_count   <= w_count_nxt;
      r_result  <= w_result_nxt;
      r_acc     <= w_acc_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divs    <= w_divs_nxt;
    end
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    busy      = (r_state != StIdle);
    result    = r_result;
    rd_out    = r_rd;
    we_out    = r_we && (r_state == StDone);
  end

endmodule
